// File: rtl/din_sequencer.sv
// Instruction sequencer feeding the processor din port: fetches instruction and
// immediate words from program memory and gates the processor tick while memory is slow.
module din_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DIN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            tick,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [DIN_WIDTH-1:0]  mem_rdata,
    output logic [DIN_WIDTH-1:0]  proc_din,
    output logic                  proc_en,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           instr_count,
    output logic                  halted,
    output logic                  error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_FETCH_IMM = 3'd4;
    localparam logic [2:0] S_WAIT_IMM  = 3'd5;
    localparam logic [2:0] S_EXEC      = 3'd6;
    localparam logic [2:0] S_HALTED    = 3'd7;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_MOVI = 3'd7;

    function automatic logic [2:0] opcode(input logic [DIN_WIDTH-1:0] w);
        return w[DIN_WIDTH-1 -: 3];
    endfunction

    function automatic logic is_imm(input logic [2:0] op);
        return (op == OP_ADDI) || (op == OP_MOVI);
    endfunction

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           count_q, count_d;
    logic [DIN_WIDTH-1:0]  din_q, din_d;
    logic                  error_q, error_d;
    logic                  halted_q, halted_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  proc_en_q, proc_en_d;
    logic [1:0]            exec_cnt_q, exec_cnt_d;
    logic                  imm_gap_q, imm_gap_d;

    // Next-state logic; outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        din_d      = din_q;
        error_d    = error_q;
        exec_cnt_d = exec_cnt_q;
        imm_gap_d  = imm_gap_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = {ADDR_WIDTH{1'b0}};
                    count_d = 16'd0;
                    error_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    din_d   = mem_rdata;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = (opcode(mem_rdata) == OP_HALT) ? S_HALTED : S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ISSUE: begin
                exec_cnt_d = 2'd0;
                imm_gap_d  = 1'b0;
                if (tick != 4'b0001) begin
                    error_d = 1'b1;
                    state_d = S_HALTED;
                end else if (is_imm(opcode(din_q))) begin
                    state_d = S_FETCH_IMM;
                end else begin
                    state_d = S_EXEC;
                end
            end
            // One turnaround cycle after the IR load before the immediate is requested.
            S_FETCH_IMM: begin
                if (imm_gap_q) begin
                    state_d = S_WAIT_IMM;
                end else begin
                    imm_gap_d = 1'b1;
                end
            end
            S_WAIT_IMM: begin
                if (mem_rvalid) begin
                    din_d   = mem_rdata;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = S_EXEC;
                end else begin
                    state_d = S_WAIT_IMM;
                end
            end
            S_EXEC: begin
                if (exec_cnt_q == 2'd2) begin
                    count_d = count_q + 16'd1;
                    state_d = S_FETCH;
                end else begin
                    exec_cnt_d = exec_cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        halted_d   = (state_d == S_HALTED);
        proc_en_d  = (state_d == S_ISSUE) || (state_d == S_EXEC);
        mem_req_d  = (state_d == S_FETCH) || ((state_d == S_FETCH_IMM) && imm_gap_d);
        mem_addr_d = mem_req_d ? pc_d : mem_addr_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= {ADDR_WIDTH{1'b0}};
            count_q    <= 16'd0;
            din_q      <= {DIN_WIDTH{1'b0}};
            error_q    <= 1'b0;
            halted_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= {ADDR_WIDTH{1'b0}};
            proc_en_q  <= 1'b0;
            exec_cnt_q <= 2'd0;
            imm_gap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            din_q      <= din_d;
            error_q    <= error_d;
            halted_q   <= halted_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            proc_en_q  <= proc_en_d;
            exec_cnt_q <= exec_cnt_d;
            imm_gap_q  <= imm_gap_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign proc_din    = din_q;
    assign proc_en     = proc_en_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign halted      = halted_q;
    assign error       = error_q;

endmodule
